// File: rtl/async_fifo_prog.sv
// Dual-clock FIFO with Gray-coded pointer crossing, programmable
// almost-full/almost-empty thresholds, sticky error flags and FWFT mode.
`timescale 1ns/1ps
module async_fifo_prog #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FWFT        = 0
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH:0]   afull_thresh,
  output logic                  full,
  output logic                  afull,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  overflow,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   aempty_thresh,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  aempty,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  typedef logic [PW-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PW-1] = g[PW-1];
    for (int i = PW-2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  ptr_t wr_ptr, wr_gray, rd_ptr, rd_gray;
  ptr_t rd_sync [SYNC_STAGES];
  ptr_t wr_sync [SYNC_STAGES];

  logic wr_vld, full_nxt;
  ptr_t wr_ptr_nxt, wr_gray_nxt, rd_bin_sync, wr_cnt_nxt;

  logic rd_vld, empty_nxt;
  ptr_t rd_ptr_nxt, rd_gray_nxt, wr_bin_sync, rd_cnt_nxt;

  // Write-side next-state: pointer advance, full compare, occupancy
  always_comb begin
    wr_vld      = wr_en & ~full;
    wr_ptr_nxt  = wr_ptr + ptr_t'(wr_vld);
    wr_gray_nxt = bin2gray(wr_ptr_nxt);
    rd_bin_sync = gray2bin(rd_sync[SYNC_STAGES-1]);
    wr_cnt_nxt  = wr_ptr_nxt - rd_bin_sync;
    full_nxt    = (wr_gray_nxt ==
                   {~rd_sync[SYNC_STAGES-1][PW-1:PW-2],
                    rd_sync[SYNC_STAGES-1][PW-3:0]});
  end

  // Write-domain state and flags
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_ptr   <= '0;
      wr_gray  <= '0;
      full     <= 1'b0;
      afull    <= 1'b0;
      wr_count <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      wr_gray  <= wr_gray_nxt;
      full     <= full_nxt;
      afull    <= (wr_cnt_nxt >= afull_thresh);
      wr_count <= wr_cnt_nxt;
      overflow <= overflow | (wr_en & full);
    end
  end

  // Read Gray pointer brought into the write domain
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        rd_sync[i] <= '0;
    end else begin
      rd_sync[0] <= rd_gray;
      for (int i = 1; i < SYNC_STAGES; i++)
        rd_sync[i] <= rd_sync[i-1];
    end
  end

  // Storage array, write port only, no reset
  always_ff @(posedge wr_clk) begin
    if (wr_vld)
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
  end

  // Read-side next-state: pointer advance, empty compare, occupancy
  always_comb begin
    rd_vld      = rd_en & ~empty;
    rd_ptr_nxt  = rd_ptr + ptr_t'(rd_vld);
    rd_gray_nxt = bin2gray(rd_ptr_nxt);
    wr_bin_sync = gray2bin(wr_sync[SYNC_STAGES-1]);
    rd_cnt_nxt  = wr_bin_sync - rd_ptr_nxt;
    empty_nxt   = (rd_gray_nxt == wr_sync[SYNC_STAGES-1]);
  end

  // Read-domain state and flags
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_ptr    <= '0;
      rd_gray   <= '0;
      empty     <= 1'b1;
      aempty    <= 1'b1;
      rd_count  <= '0;
      underflow <= 1'b0;
    end else begin
      rd_ptr    <= rd_ptr_nxt;
      rd_gray   <= rd_gray_nxt;
      empty     <= empty_nxt;
      aempty    <= (rd_cnt_nxt <= aempty_thresh);
      rd_count  <= rd_cnt_nxt;
      underflow <= underflow | (rd_en & empty);
    end
  end

  // Write Gray pointer brought into the read domain
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        wr_sync[i] <= '0;
    end else begin
      wr_sync[0] <= wr_gray;
      for (int i = 1; i < SYNC_STAGES; i++)
        wr_sync[i] <= wr_sync[i-1];
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is prefetched every edge so it is present with ~empty
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n)
        rd_data <= '0;
      else
        rd_data <= mem[rd_ptr_nxt[ADDR_WIDTH-1:0]];
    end
    assign rd_valid = ~empty;
  end else begin : g_std
    logic valid_q;
    // Registered read: data and valid one cycle after accepted rd_en
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
        valid_q <= 1'b0;
        rd_data <= '0;
      end else begin
        valid_q <= rd_vld;
        if (rd_vld)
          rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
    end
    assign rd_valid = valid_q;
  end

endmodule
